// File: rtl/campo_asteroides_if.sv
// Handshake and read-port bundle for the asteroid field.
//   spawn_*   : request to place a new asteroid in the lowest free slot
//   destroi_* : shot-hit request that destroys one slot
//   le_*      : combinational slot read port for the renderer / control unit
// The master modport belongs to the control side and the slave modport to campo_asteroides.
interface campo_asteroides_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned COOR_W = 4
);
    logic              spawn_valid;
    logic              spawn_ready;
    logic [COOR_W-1:0] spawn_x;
    logic [COOR_W-1:0] spawn_y;
    logic [1:0]        spawn_opcode;

    logic              destroi_valid;
    logic              destroi_ready;
    logic [ADDR_W-1:0] destroi_addr;

    logic [ADDR_W-1:0] le_addr;
    logic [COOR_W-1:0] le_x;
    logic [COOR_W-1:0] le_y;
    logic [1:0]        le_opcode;
    logic              le_loaded;
    logic              le_destruido;

    modport master (
        output spawn_valid, spawn_x, spawn_y, spawn_opcode,
        output destroi_valid, destroi_addr, le_addr,
        input  spawn_ready, destroi_ready,
        input  le_x, le_y, le_opcode, le_loaded, le_destruido
    );

    modport slave (
        input  spawn_valid, spawn_x, spawn_y, spawn_opcode,
        input  destroi_valid, destroi_addr, le_addr,
        output spawn_ready, destroi_ready,
        output le_x, le_y, le_opcode, le_loaded, le_destruido
    );
endinterface

// File: rtl/campo_asteroides.sv
// Asteroid field: N_ASTE-slot table plus a sweep FSM that moves every loaded asteroid one step
// per `iniciar` pulse and checks it against the ship position.
//   clock, reset_n      : clock and synchronous active-low reset
//   iniciar             : sweep start pulse (accepted only when idle)
//   nave_x, nave_y      : ship position, used during the sweep
//   bus                 : spawn / destroy handshakes and the combinational slot read port
//   pronto              : one-cycle pulse when a sweep completes
//   ocupado             : high whenever the FSM is not idle
//   colisao             : any collision seen in the last completed sweep
//   colisao_count       : saturating collision total since reset
//   ativos              : number of loaded slots
module campo_asteroides #(
    parameter int unsigned N_ASTE = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned COOR_W = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                iniciar,
    input  logic [COOR_W-1:0]   nave_x,
    input  logic [COOR_W-1:0]   nave_y,
    campo_asteroides_if.slave   bus,
    output logic                pronto,
    output logic                ocupado,
    output logic                colisao,
    output logic [CNT_W-1:0]    colisao_count,
    output logic [ADDR_W:0]     ativos
);
    typedef enum logic [1:0] {StOcioso, StLe, StAtualiza, StFim} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [COOR_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [1:0]        cur_op_q, cur_op_d;
    logic              cur_ld_q, cur_ld_d;
    logic              pronto_q, pronto_d;
    logic              colisao_q, colisao_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W:0]   ativos_q, ativos_d;

    logic [COOR_W-1:0] tab_x_q [N_ASTE];
    logic [COOR_W-1:0] tab_x_d [N_ASTE];
    logic [COOR_W-1:0] tab_y_q [N_ASTE];
    logic [COOR_W-1:0] tab_y_d [N_ASTE];
    logic [1:0]        tab_op_q [N_ASTE];
    logic [1:0]        tab_op_d [N_ASTE];
    logic              tab_ld_q [N_ASTE];
    logic              tab_ld_d [N_ASTE];
    logic              tab_de_q [N_ASTE];
    logic              tab_de_d [N_ASTE];

    logic              free_found;
    logic [ADDR_W-1:0] free_idx;
    logic              accept, spawn_fire, destroi_fire;
    logic [COOR_W:0]   nx, ny;
    logic              sai, hit;

    // Lowest-index free slot.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < N_ASTE; i++) begin
            if (!tab_ld_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = ADDR_W'(i);
            end
        end
    end

    assign accept            = (state_q == StOcioso) && !iniciar;
    assign bus.spawn_ready   = accept && free_found;
    assign bus.destroi_ready = accept;
    assign spawn_fire        = bus.spawn_valid && bus.spawn_ready;
    assign destroi_fire      = bus.destroi_valid && bus.destroi_ready;

    // One extra bit so leaving the field shows up as a carry/borrow in the MSB.
    always_comb begin
        nx = {1'b0, cur_x_q};
        ny = {1'b0, cur_y_q};
        unique case (cur_op_q)
            2'b00: nx = {1'b0, cur_x_q} + (COOR_W+1)'(1);
            2'b01: nx = {1'b0, cur_x_q} - (COOR_W+1)'(1);
            2'b10: ny = {1'b0, cur_y_q} + (COOR_W+1)'(1);
            default: ny = {1'b0, cur_y_q} - (COOR_W+1)'(1);
        endcase
    end

    assign sai = nx[COOR_W] || ny[COOR_W];
    assign hit = cur_ld_q &&
                 (((cur_x_q == nave_x) && (cur_y_q == nave_y)) ||
                  (!sai && (nx[COOR_W-1:0] == nave_x) && (ny[COOR_W-1:0] == nave_y)));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        cur_op_d  = cur_op_q;
        cur_ld_d  = cur_ld_q;
        pronto_d  = 1'b0;
        colisao_d = colisao_q;
        count_d   = count_q;
        ativos_d  = ativos_q;
        tab_x_d   = tab_x_q;
        tab_y_d   = tab_y_q;
        tab_op_d  = tab_op_q;
        tab_ld_d  = tab_ld_q;
        tab_de_d  = tab_de_q;

        unique case (state_q)
            StOcioso: begin
                if (iniciar) begin
                    state_d   = StLe;
                    idx_d     = '0;
                    colisao_d = 1'b0;
                end
                if (spawn_fire) begin
                    tab_x_d[free_idx]  = bus.spawn_x;
                    tab_y_d[free_idx]  = bus.spawn_y;
                    tab_op_d[free_idx] = bus.spawn_opcode;
                    tab_ld_d[free_idx] = 1'b1;
                    tab_de_d[free_idx] = 1'b0;
                    ativos_d           = ativos_d + (ADDR_W+1)'(1);
                end
                // Checks the pre-edge flag, so a simultaneous spawn target is never hit.
                if (destroi_fire && tab_ld_q[bus.destroi_addr]) begin
                    tab_ld_d[bus.destroi_addr] = 1'b0;
                    tab_de_d[bus.destroi_addr] = 1'b1;
                    ativos_d                   = ativos_d - (ADDR_W+1)'(1);
                end
            end
            StLe: begin
                cur_x_d  = tab_x_q[idx_q];
                cur_y_d  = tab_y_q[idx_q];
                cur_op_d = tab_op_q[idx_q];
                cur_ld_d = tab_ld_q[idx_q];
                state_d  = StAtualiza;
            end
            StAtualiza: begin
                if (cur_ld_q) begin
                    if (!sai) begin
                        tab_x_d[idx_q] = nx[COOR_W-1:0];
                        tab_y_d[idx_q] = ny[COOR_W-1:0];
                    end
                    if (hit) begin
                        tab_ld_d[idx_q] = 1'b0;
                        tab_de_d[idx_q] = 1'b1;
                        colisao_d       = 1'b1;
                        ativos_d        = ativos_q - (ADDR_W+1)'(1);
                        if (count_q != '1) begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end else if (sai) begin
                        tab_ld_d[idx_q] = 1'b0;
                        ativos_d        = ativos_q - (ADDR_W+1)'(1);
                    end
                end
                if (idx_q == ADDR_W'(N_ASTE - 1)) begin
                    state_d = StFim;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = StLe;
                end
            end
            StFim: begin
                state_d  = StOcioso;
                pronto_d = 1'b1;
            end
            default: state_d = StOcioso;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= StOcioso;
            idx_q     <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            cur_op_q  <= '0;
            cur_ld_q  <= 1'b0;
            pronto_q  <= 1'b0;
            colisao_q <= 1'b0;
            count_q   <= '0;
            ativos_q  <= '0;
            tab_x_q   <= '{default: '0};
            tab_y_q   <= '{default: '0};
            tab_op_q  <= '{default: '0};
            tab_ld_q  <= '{default: 1'b0};
            tab_de_q  <= '{default: 1'b0};
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            cur_op_q  <= cur_op_d;
            cur_ld_q  <= cur_ld_d;
            pronto_q  <= pronto_d;
            colisao_q <= colisao_d;
            count_q   <= count_d;
            ativos_q  <= ativos_d;
            tab_x_q   <= tab_x_d;
            tab_y_q   <= tab_y_d;
            tab_op_q  <= tab_op_d;
            tab_ld_q  <= tab_ld_d;
            tab_de_q  <= tab_de_d;
        end
    end

    assign bus.le_x         = tab_x_q[bus.le_addr];
    assign bus.le_y         = tab_y_q[bus.le_addr];
    assign bus.le_opcode    = tab_op_q[bus.le_addr];
    assign bus.le_loaded    = tab_ld_q[bus.le_addr];
    assign bus.le_destruido = tab_de_q[bus.le_addr];

    assign pronto        = pronto_q;
    assign ocupado       = (state_q != StOcioso);
    assign colisao       = colisao_q;
    assign colisao_count = count_q;
    assign ativos        = ativos_q;
endmodule

// File: doc/campo_asteroides.md
Name: campo_asteroides

Overview:
- Parametrised successor of the single-datapath asteroid block: owns an N-slot asteroid table (x, y, opcode, loaded, destruido) and a sweep FSM.
- On each `iniciar` pulse the FSM moves every loaded asteroid one step and checks it against the ship position.
- It also handles spawn and destroy handshakes and exposes a combinational read port for the display/UC.
- Sits between the game control unit (issues `iniciar`/spawn/destroy) and the renderer (reads slots).

Parameters:
- N_ASTE, 16, number of asteroid slots (power of 2, ≥2).
- ADDR_W, 4, slot address width, log2(N_ASTE).
- COOR_W, 4, coordinate width; field is 0..2^COOR_W-1 on each axis.
- CNT_W, 8, width of the collision counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous reset, active-low.
- iniciar  in  1  one-cycle pulse; starts a sweep; accepted only in OCIOSO.
- nave_x  in  COOR_W  ship x, sampled every cycle during the sweep.
- nave_y  in  COOR_W  ship y.
- spawn_valid  in  1  spawn request.
- spawn_ready  out  1  spawn accepted when valid&ready.
- spawn_x, spawn_y  in  COOR_W each  new asteroid position.
- spawn_opcode  in  2  new asteroid direction.
- destroi_valid  in  1  shot-hit request.
- destroi_ready  out  1  destroy accepted when valid&ready.
- destroi_addr  in  ADDR_W  slot to destroy.
- le_addr  in  ADDR_W  read-port slot select.
- le_x, le_y  out  COOR_W  slot coordinates (combinational).
- le_opcode  out  2  slot opcode.
- le_loaded, le_destruido  out  1  slot flags.
- pronto  out  1  one-cycle pulse at sweep end.
- ocupado  out  1  high in every state except OCIOSO.
- colisao  out  1  sticky: any collision in the last completed sweep.
- colisao_count  out  CNT_W  total collisions since reset; saturating.
- ativos  out  ADDR_W+1  number of loaded slots.

Behaviour:
- Reset (reset_n=0 at a clock edge), same edge:
  - all slots cleared: x=y=opcode=0, loaded=0, destruido=0;
  - FSM goes to OCIOSO;
  - pronto=0, colisao=0, colisao_count=0, ativos=0.
  - Reset mid-sweep aborts the sweep; no pronto is issued.
- Opcode encoding:
  - 00 = x+1; 01 = x-1; 10 = y+1; 11 = y-1.
  - Arithmetic is COOR_W+1 bits.
  - Any carry/borrow out (x=max with +1, x=0 with -1, same for y) means the asteroid leaves the field: loaded←0, destruido unchanged, no collision.
  - No wrap-around.
- FSM states:
  - OCIOSO → (iniciar) LE, with slot index i←0 and colisao←0.
  - LE: register slot i.
  - ATUALIZA: compute the new position and the collision, write slot i back.
    - If i = N_ASTE-1 → FIM; else i←i+1 and → LE.
  - FIM: pronto=1 for one cycle → OCIOSO.
- Sweep latency: `iniciar` sampled at edge 0; pronto is high during the cycle after edge 2·N_ASTE+1.
- Unloaded slots pass LE/ATUALIZA without modification; the sweep length is fixed.
- Collision test for a loaded slot: old position == nave OR new in-field position == nave. On a collision:
  - loaded←0, destruido←1;
  - colisao←1;
  - colisao_count += 1, saturating at 2^CNT_W-1.
- spawn_ready = (state==OCIOSO) & !iniciar & (some slot with loaded=0).
  - On accept, the lowest-index free slot is written at the next edge: x, y, opcode, loaded←1, destruido←0.
  - Spawn is not collision-checked.
- destroi_ready = (state==OCIOSO) & !iniciar.
  - On accept, if slot destroi_addr is loaded: loaded←0, destruido←1. Otherwise no effect.
- Spawn and destroy accepted in the same cycle are both applied.
  - They cannot conflict: the spawn target is free, so a destroy of that slot is a no-op.
- `iniciar` outside OCIOSO is ignored.
- ativos tracks the number of loaded slots, updated with each write.
- Read port is asynchronous. A write to le_addr becomes visible after the write edge.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles, then spawn 16 times → slots 0..15 loaded in order, ativos=16, spawn_ready=0 on the 17th request.
- Movement:
  - slot0 (3,5,op00) → (4,5);
  - slot1 (3,5,op11) → (3,4) after one sweep;
  - pronto is high exactly 33 cycles after the `iniciar` edge (N_ASTE=16).
- Edge exit:
  - slot (15,2,op00) → loaded=0, destruido=0, ativos decrements;
  - slot (0,9,op01) likewise.
- Collision: nave=(7,7), slot (6,7,op00) → destruido=1, loaded=0, colisao=1, colisao_count=1. The next sweep with no hits clears colisao to 0 and leaves the count at 1.
- Destroy and handshake:
  - destroi slot 2 in OCIOSO → destruido=1;
  - destroi_valid during a sweep → destroi_ready=0, table unchanged;
  - simultaneous spawn+destroi both applied.
- Reset mid-sweep at slot 8 → all slots cleared, ocupado=0, no pronto pulse.
